// File: rtl/drac_pkg.sv
// ============================================================================
// drac_pkg
// Shared sizes and types for the rename / free-list datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

package drac_pkg;

  localparam int NUM_PHYSICAL_REGISTERS = 64;
  localparam int NUM_ISA_REGISTERS      = 32;
  localparam int NUM_CHECKPOINTS        = 4;
  localparam int FL_SIZE                = NUM_PHYSICAL_REGISTERS - NUM_ISA_REGISTERS;

  typedef logic [$clog2(NUM_PHYSICAL_REGISTERS)-1:0] phreg_t;
  typedef logic [$clog2(NUM_CHECKPOINTS)-1:0]        checkpoint_ptr;
  // Free-list pointer: index bits plus one wrap bit
  typedef logic [$clog2(FL_SIZE):0]                  fl_ptr_t;

endpackage

`default_nettype wire

// File: rtl/phys_free_list_if.sv
// ============================================================================
// phys_free_list_if
// Control/data bundle between the rename stage (master) and the physical
// register free list (slave).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface phys_free_list_if;
  import drac_pkg::*;

  logic               read_head_i;
  logic [1:0]         add_free_register_i;
  phreg_t [1:0]       free_register_i;
  logic               commit_roll_back_i;
  logic               do_checkpoint_i;
  logic               do_recover_i;
  logic               delete_checkpoint_i;
  checkpoint_ptr      recover_checkpoint_i;
  phreg_t             new_register_o;
  checkpoint_ptr      checkpoint_o;
  logic               out_of_checkpoints_o;
  logic               empty_o;

  modport master (
    output read_head_i, add_free_register_i, free_register_i, commit_roll_back_i,
    output do_checkpoint_i, do_recover_i, delete_checkpoint_i, recover_checkpoint_i,
    input  new_register_o, checkpoint_o, out_of_checkpoints_o, empty_o
  );

  modport slave (
    input  read_head_i, add_free_register_i, free_register_i, commit_roll_back_i,
    input  do_checkpoint_i, do_recover_i, delete_checkpoint_i, recover_checkpoint_i,
    output new_register_o, checkpoint_o, out_of_checkpoints_o, empty_o
  );

endinterface

`default_nettype wire

// File: rtl/phys_free_list.sv
// ============================================================================
// phys_free_list
// Circular free list of physical registers with head checkpoints for branch
// recovery and full restore on commit roll-back.
// Optional macro PHYS_FREE_LIST_CHECK_EN adds a sticky debug error flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module phys_free_list
  import drac_pkg::*;
(
  input  logic            clk_i,
  input  logic            rstn_i,
  phys_free_list_if.slave fl
);

  localparam int            IDX_W       = $clog2(FL_SIZE);
  localparam fl_ptr_t       FL_SIZE_PTR = fl_ptr_t'(FL_SIZE);
  localparam checkpoint_ptr MAX_CKPT    = checkpoint_ptr'(NUM_CHECKPOINTS - 1);

  typedef logic [IDX_W-1:0] fl_idx_t;

  phreg_t        fifo      [FL_SIZE];
  fl_ptr_t       head_ckpt [NUM_CHECKPOINTS];
  fl_ptr_t       head;
  fl_ptr_t       tail;
  checkpoint_ptr version_head;
  checkpoint_ptr version_tail;
  checkpoint_ptr num_checkpoints;
  phreg_t        new_register;

  fl_ptr_t       count;
  logic          empty;
  logic          alloc;
  logic [1:0]    free_valid;
  fl_ptr_t       num_frees;
  fl_ptr_t       tail_next;
  fl_ptr_t       head_alloc;
  fl_idx_t       wr_idx0;
  fl_idx_t       wr_idx1;
  logic          take_ckpt;

  // Occupancy, allocation/free qualification and next pointers
  always_comb begin
    count         = tail - head;
    empty         = (count == '0);
    alloc         = fl.read_head_i & ~empty & ~fl.do_recover_i & ~fl.commit_roll_back_i;
    free_valid[0] = fl.add_free_register_i[0] & (fl.free_register_i[0] != '0);
    free_valid[1] = fl.add_free_register_i[1] & (fl.free_register_i[1] != '0);
    num_frees     = fl_ptr_t'(free_valid[0]) + fl_ptr_t'(free_valid[1]);
    tail_next     = tail + num_frees;
    head_alloc    = head + fl_ptr_t'(alloc);
    // Port 1 lands right after port 0 only when port 0 actually wrote
    wr_idx0       = fl_idx_t'(tail);
    wr_idx1       = fl_idx_t'(tail + fl_ptr_t'(free_valid[0]));
    take_ckpt     = fl.do_checkpoint_i & (num_checkpoints < MAX_CKPT) &
                    ~fl.do_recover_i & ~fl.commit_roll_back_i;
  end

  // Free-list storage: returned registers are appended at the tail
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FL_SIZE; i++) fifo[i] <= phreg_t'(NUM_ISA_REGISTERS + i);
    end else begin
      if (free_valid[0]) fifo[wr_idx0] <= fl.free_register_i[0];
      if (free_valid[1]) fifo[wr_idx1] <= fl.free_register_i[1];
    end
  end

  // Head/tail pointers: roll-back refills the list, recovery restores head
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head <= '0;
      tail <= FL_SIZE_PTR;
    end else begin
      tail <= tail_next;
      if (fl.commit_roll_back_i)  head <= tail_next - FL_SIZE_PTR;
      else if (fl.do_recover_i)   head <= head_ckpt[fl.recover_checkpoint_i];
      else                        head <= head_alloc;
    end
  end

  // Checkpoint copies of head, taken after this cycle's allocation
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_CHECKPOINTS; i++) head_ckpt[i] <= '0;
    end else if (take_ckpt) begin
      head_ckpt[checkpoint_ptr'(version_head + 1'b1)] <= head_alloc;
    end
  end

  // Checkpoint version bookkeeping
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      version_head    <= '0;
      version_tail    <= '0;
      num_checkpoints <= '0;
    end else if (fl.commit_roll_back_i) begin
      version_head    <= '0;
      version_tail    <= '0;
      num_checkpoints <= '0;
    end else begin
      if (fl.do_recover_i) begin
        version_head    <= fl.recover_checkpoint_i;
        num_checkpoints <= fl.recover_checkpoint_i - version_tail;
      end else begin
        if (take_ckpt) version_head <= version_head + 1'b1;
        num_checkpoints <= num_checkpoints + checkpoint_ptr'(take_ckpt)
                           - checkpoint_ptr'(fl.delete_checkpoint_i);
      end
      if (fl.delete_checkpoint_i) version_tail <= version_tail + 1'b1;
    end
  end

  // Allocated register output, held when nothing is allocated
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)    new_register <= '0;
    else if (alloc) new_register <= fifo[fl_idx_t'(head)];
  end

  assign fl.new_register_o       = new_register;
  assign fl.checkpoint_o         = version_head;
  assign fl.out_of_checkpoints_o = (num_checkpoints == MAX_CKPT);
  assign fl.empty_o              = empty;

`ifdef PHYS_FREE_LIST_CHECK_EN
  (* keep = "true", mark_debug = "true" *) logic error_q;

  // Sticky flag for overfill and reads of an empty list
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      error_q <= 1'b0;
    end else if (((num_frees != '0) && (count == FL_SIZE_PTR)) ||
                 ((count + num_frees) > FL_SIZE_PTR) ||
                 (fl.read_head_i && empty)) begin
      error_q <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_phys_free_list.sv
// ============================================================================
// tb_phys_free_list
// Self-checking bench for phys_free_list: vector table plus hand sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_phys_free_list;
  import drac_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  phys_free_list_if fl ();

  phys_free_list dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .fl     (fl)
  );

  typedef struct {
    logic          rd;
    logic [1:0]    add;
    phreg_t        f0;
    phreg_t        f1;
    logic          ck;
    logic          rc;
    checkpoint_ptr rp;
    logic          del;
    logic          rb;
    phreg_t        e_new;
    logic          e_empty;
    checkpoint_ptr e_ck;
    logic          e_ooc;
  } vec_t;

  int     checks   = 0;
  int     failures = 0;
  phreg_t sb[$];
  vec_t   tbl[$];

  function automatic vec_t mk(input logic rd, input logic [1:0] add, input int f0, input int f1,
                              input logic ck, input logic rc, input int rp, input logic del,
                              input logic rb, input int e_new, input logic e_empty,
                              input int e_ck, input logic e_ooc);
    vec_t v;
    v.rd = rd; v.add = add; v.f0 = phreg_t'(f0); v.f1 = phreg_t'(f1);
    v.ck = ck; v.rc = rc; v.rp = checkpoint_ptr'(rp); v.del = del; v.rb = rb;
    v.e_new = phreg_t'(e_new); v.e_empty = e_empty; v.e_ck = checkpoint_ptr'(e_ck);
    v.e_ooc = e_ooc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    fl.read_head_i          = 1'b0;
    fl.add_free_register_i  = 2'b00;
    fl.free_register_i[0]   = '0;
    fl.free_register_i[1]   = '0;
    fl.commit_roll_back_i   = 1'b0;
    fl.do_checkpoint_i      = 1'b0;
    fl.do_recover_i         = 1'b0;
    fl.delete_checkpoint_i  = 1'b0;
    fl.recover_checkpoint_i = '0;
  endtask

  // Drive one cycle of stimulus, queue its expected register, compare after the edge
  task automatic apply(input vec_t t, input string nm);
    phreg_t exp_new;
    fl.read_head_i          = t.rd;
    fl.add_free_register_i  = t.add;
    fl.free_register_i[0]   = t.f0;
    fl.free_register_i[1]   = t.f1;
    fl.do_checkpoint_i      = t.ck;
    fl.do_recover_i         = t.rc;
    fl.recover_checkpoint_i = t.rp;
    fl.delete_checkpoint_i  = t.del;
    fl.commit_roll_back_i   = t.rb;
    sb.push_back(t.e_new);
    @(posedge clk);
    #1;
    exp_new = sb.pop_front();
    check({nm, ".new"},   32'(fl.new_register_o),       32'(exp_new));
    check({nm, ".empty"}, 32'(fl.empty_o),              32'(t.e_empty));
    check({nm, ".ckpt"},  32'(fl.checkpoint_o),         32'(t.e_ck));
    check({nm, ".ooc"},   32'(fl.out_of_checkpoints_o), 32'(t.e_ooc));
    idle();
  endtask

  task automatic do_reset(input bit chk);
    #3;
    rstn = 1'b0;
    #1;
    if (chk) begin
      check("async_rst.new",   32'(fl.new_register_o),       0);
      check("async_rst.ckpt",  32'(fl.checkpoint_o),         0);
      check("async_rst.empty", 32'(fl.empty_o),              0);
      check("async_rst.ooc",   32'(fl.out_of_checkpoints_o), 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    do_reset(1'b0);
    check("reset.new",   32'(fl.new_register_o),       0);
    check("reset.ckpt",  32'(fl.checkpoint_o),         0);
    check("reset.empty", 32'(fl.empty_o),              0);
    check("reset.ooc",   32'(fl.out_of_checkpoints_o), 0);
    check("reset.head",  32'(dut.head),                0);
    check("reset.tail",  32'(dut.tail),                32);

    //        rd add f0 f1 ck rc rp del rb  new em ck ooc
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32, 0, 0, 0)); // first allocations
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 33, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 33, 0, 1, 0)); // checkpoint 1 at head 2
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 34, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 35, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 35, 0, 1, 0)); // recover blocks read
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 34, 0, 1, 0)); // 34 handed out again
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 34, 0, 1, 0)); // delete -> num 0
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 34, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 34, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 34, 0, 0, 1)); // third -> out of ckpts
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 34, 0, 0, 1)); // fourth refused
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 34, 0, 0, 0)); // delete clears ooc
    tbl.push_back(mk(0, 3, 5, 7, 0, 0, 0, 0, 0, 34, 0, 0, 0)); // free 5,7
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 34, 0, 0, 0)); // phreg 0 ignored
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 34, 0, 0, 0)); // phreg 0 ignored
    tbl.push_back(mk(1, 2, 0, 9, 1, 0, 0, 1, 1, 34, 0, 0, 0)); // roll-back wins, free kept
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 35, 0, 0, 0)); // head = 35-32 = 3
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 36, 0, 1, 0)); // ckpt captures head 5
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 37, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 37, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 37, 0, 1, 0)); // post-alloc head restored

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    check("table.tail",    32'(dut.tail),            35);
    check("table.head",    32'(dut.head),            6);
    check("table.fifo0",   32'(dut.fifo[0]),         5);
    check("table.fifo1",   32'(dut.fifo[1]),         7);
    check("table.fifo2",   32'(dut.fifo[2]),         9);
    check("table.numckpt", 32'(dut.num_checkpoints), 1);

    // Drain the list completely, then try to allocate with a same-cycle free
    do_reset(1'b1);
    for (int i = 0; i < 32; i++)
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32 + i, (i == 31), 0, 0), $sformatf("drain%0d", i));
    check("drain.head", 32'(dut.head), 32);
    check("drain.tail", 32'(dut.tail), 32);
    apply(mk(1, 1, 12, 0, 0, 0, 0, 0, 0, 63, 0, 0, 0), "empty_read");
    check("empty_read.head", 32'(dut.head), 32);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 12, 1, 0, 0), "refill_read");

    // Allocate 10 with a checkpoint, free 2, then roll back
    do_reset(1'b1);
    for (int i = 0; i < 10; i++)
      apply(mk(1, 0, 0, 0, (i == 4), 0, 0, 0, 0, 32 + i, 0, (i >= 4) ? 1 : 0, 0),
            $sformatf("rb_alloc%0d", i));
    apply(mk(0, 3, 40, 41, 0, 0, 0, 0, 0, 41, 0, 1, 0), "rb_free");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 41, 0, 0, 0), "rb_rollback");
    check("rb.tail",    32'(dut.tail),                  34);
    check("rb.head",    32'(dut.head),                  2);
    check("rb.count",   32'(fl_ptr_t'(dut.tail - dut.head)), 32);
    check("rb.numckpt", 32'(dut.num_checkpoints),       0);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 34, 0, 0, 0), "rb_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
